// File: rtl/gpio_rgb_scheduler_pkg.sv
// Shared types and constants for the GPIO R/G/B word scheduler.
package gpio_sched_pkg;

  localparam int CH_COUNT = 3;

  // wrCh encoding; 2'd3 is not a channel and flags an error
  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } channel_e;

  localparam logic [1:0] CH_INVALID = 2'd3;

  // Scheduler states; encodings are fixed so the top can reuse them as plain constants
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EMIT_R = 3'd1,
    ST_EMIT_G = 3'd2,
    ST_EMIT_B = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/gpio_rgb_scheduler_if.sv
// Core-side write port and GPIO pin bundle of the R/G/B scheduler.
interface gpio_rgb_scheduler_if;

  logic        start;
  logic        wrEn;
  logic [1:0]  wrCh;
  logic [31:0] wrData;
  logic        gpioHold;
  logic        fullR;
  logic        fullG;
  logic        fullB;
  logic [31:0] GPIO;
  logic        GPIOEnR;
  logic        GPIOEnG;
  logic        GPIOEnB;
  logic        GPIOEn;
  logic        done;
  logic        errFlag;

  // Core / board side: issues writes and backpressure, observes the pins
  modport master (
    output start, wrEn, wrCh, wrData, gpioHold,
    input  fullR, fullG, fullB, GPIO, GPIOEnR, GPIOEnG, GPIOEnB, GPIOEn, done, errFlag
  );

  // Scheduler side
  modport slave (
    input  start, wrEn, wrCh, wrData, gpioHold,
    output fullR, fullG, fullB, GPIO, GPIOEnR, GPIOEnG, GPIOEnB, GPIOEn, done, errFlag
  );

endinterface

// File: rtl/gpio_rgb_scheduler_fifo.sv
// Per-channel synchronous FIFO. A push into a full FIFO only lands when a pop
// frees the slot in the same cycle; a pop on an empty FIFO is ignored, so a
// word pushed into an empty FIFO becomes poppable one cycle later (no bypass).
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   occ_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (occ_reg == (PTR_W + 1)'(DEPTH));
  assign empty   = (occ_reg == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Head word is presented continuously; the consumer registers it on pop
  assign rd_data = mem[rd_ptr_reg];

  // Storage array: written on accepted pushes, never reset
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; occupancy tracks fill level
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   occ_reg <= occ_reg + (PTR_W + 1)'(1);
        2'b01:   occ_reg <= occ_reg - (PTR_W + 1)'(1);
        default: occ_reg <= occ_reg;
      endcase
    end
  end

endmodule

// File: rtl/gpio_rgb_scheduler.sv
// Buffers R/G/B result words from the vector core and drains them onto the
// shared GPIO bus in strict R->G->B order, one frame of FRAME_WORDS triples
// per start pulse.
module gpio_rgb_scheduler
  import gpio_sched_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int FRAME_WORDS = 40000
) (
  input  logic                 clk,
  input  logic                 rst,
  gpio_rgb_scheduler_if.slave  io
);

  localparam int               CNT_W    = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_WORDS - 1);

  localparam logic [2:0] IDLE   = ST_IDLE;
  localparam logic [2:0] EMIT_R = ST_EMIT_R;
  localparam logic [2:0] EMIT_G = ST_EMIT_G;
  localparam logic [2:0] EMIT_B = ST_EMIT_B;
  localparam logic [2:0] DONE   = ST_DONE;

  logic [2:0]          state_reg;
  logic [2:0]          state_next;
  logic [CNT_W-1:0]    cnt_reg;
  logic [CNT_W-1:0]    cnt_next;

  logic [CH_COUNT-1:0] sel_vec;
  logic [CH_COUNT-1:0] push_vec;
  logic [CH_COUNT-1:0] pop_vec;
  logic [CH_COUNT-1:0] full_vec;
  logic [CH_COUNT-1:0] empty_vec;
  logic [31:0]         rd_data [CH_COUNT];

  logic [31:0]         beat_data;
  logic                beat;
  logic                wr_err;

  logic [CH_COUNT-1:0] strobe_reg;
  logic [31:0]         gpio_reg;
  logic                gpio_en_reg;
  logic                done_reg;
  logic                err_reg;

  // Which channel the FSM is currently waiting to emit (bit index = channel code)
  assign sel_vec = {state_reg == EMIT_B, state_reg == EMIT_G, state_reg == EMIT_R};

  genvar gi;
  generate
    for (gi = 0; gi < CH_COUNT; gi++) begin : g_ch
      assign push_vec[gi] = io.wrEn && (io.wrCh == 2'(gi));
      assign pop_vec[gi]  = sel_vec[gi] && !empty_vec[gi] && !io.gpioHold;

      sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_vec[gi]),
        .pop     (pop_vec[gi]),
        .wr_data (io.wrData),
        .rd_data (rd_data[gi]),
        .full    (full_vec[gi]),
        .empty   (empty_vec[gi])
      );
    end
  endgenerate

  assign beat = |pop_vec;

  // Overflow (no same-channel pop to make room) or an invalid channel code
  assign wr_err = io.wrEn && ((io.wrCh == CH_INVALID) || (|(push_vec & full_vec & ~pop_vec)));

  // Select the word being popped; at most one channel pops per cycle
  always_comb begin
    beat_data = '0;
    for (int c = 0; c < CH_COUNT; c++) begin
      if (pop_vec[c]) begin
        beat_data = rd_data[c];
      end
    end
  end

  // Next-state and frame counter: advance only on an emitted beat, count B beats
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (io.start) begin
          state_next = EMIT_R;
        end
      end
      EMIT_R: begin
        if (pop_vec[CH_R]) begin
          state_next = EMIT_G;
        end
      end
      EMIT_G: begin
        if (pop_vec[CH_G]) begin
          state_next = EMIT_B;
        end
      end
      EMIT_B: begin
        if (pop_vec[CH_B]) begin
          if (cnt_reg == LAST_CNT) begin
            state_next = DONE;
            cnt_next   = '0;
          end else begin
            state_next = EMIT_R;
            cnt_next   = cnt_reg + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // State, counter and all registered pin outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      strobe_reg  <= '0;
      gpio_reg    <= '0;
      gpio_en_reg <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      strobe_reg <= pop_vec;
      if (beat) begin
        gpio_reg <= beat_data;
      end
      done_reg <= (state_reg == DONE);
      if (state_reg == DONE) begin
        gpio_en_reg <= 1'b0;
      end else if (pop_vec[CH_R]) begin
        gpio_en_reg <= 1'b1;
      end
      // A new error in the same cycle as an accepted start still sticks
      if (wr_err) begin
        err_reg <= 1'b1;
      end else if ((state_reg == IDLE) && io.start) begin
        err_reg <= 1'b0;
      end
    end
  end

  assign io.fullR   = full_vec[CH_R];
  assign io.fullG   = full_vec[CH_G];
  assign io.fullB   = full_vec[CH_B];
  assign io.GPIO    = gpio_reg;
  assign io.GPIOEnR = strobe_reg[CH_R];
  assign io.GPIOEnG = strobe_reg[CH_G];
  assign io.GPIOEnB = strobe_reg[CH_B];
  assign io.GPIOEn  = gpio_en_reg;
  assign io.done    = done_reg;
  assign io.errFlag = err_reg;

endmodule

// File: tb/tb_gpio_rgb_scheduler.sv
// Directed bench for gpio_rgb_scheduler: a FRAME_WORDS=2 instance for the
// ordering / stall / overflow / reset scenarios and a FRAME_WORDS=500 instance
// for a randomly streamed frame.
module tb_gpio_rgb_scheduler;

  localparam int SW = 500;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  gpio_rgb_scheduler_if bus ();
  gpio_rgb_scheduler_if bus2 ();

  gpio_rgb_scheduler #(.DEPTH(8), .FRAME_WORDS(2)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  gpio_rgb_scheduler #(.DEPTH(8), .FRAME_WORDS(SW)) dut_stream (
    .clk (clk),
    .rst (rst),
    .io  (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] s1;
  logic [2:0] s2;
  logic [2:0] f2;
  assign s1 = {bus.GPIOEnR, bus.GPIOEnG, bus.GPIOEnB};
  assign s2 = {bus2.GPIOEnR, bus2.GPIOEnG, bus2.GPIOEnB};
  assign f2 = {bus2.fullB, bus2.fullG, bus2.fullR};

  logic [31:0] r_log [$];
  logic [31:0] s_r [$];
  logic [31:0] s_g [$];
  logic [31:0] s_b [$];
  logic [31:0] sexp [3][SW];
  int          s_done;
  int          onehot_err;

  // Beat monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (bus.GPIOEnR === 1'b1) r_log.push_back(bus.GPIO);
    if (bus2.GPIOEnR === 1'b1) s_r.push_back(bus2.GPIO);
    if (bus2.GPIOEnG === 1'b1) s_g.push_back(bus2.GPIO);
    if (bus2.GPIOEnB === 1'b1) s_b.push_back(bus2.GPIO);
    if (bus2.done === 1'b1) s_done++;
    if ($countones(s1) > 1 || $countones(s2) > 1) onehot_err++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [31:0] data);
    bus.wrEn   = 1'b1;
    bus.wrCh   = ch;
    bus.wrData = data;
    tick();
    bus.wrEn = 1'b0;
    $display("write ch=%0d data=%h err=%b", ch, data, bus.errFlag);
  endtask

  task automatic wait_done(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      if (bus.done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.fullR, bus.fullG, bus.fullB, s1, bus.GPIOEn, bus.done, bus.errFlag} !== 9'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b want=000000000",
               {bus.fullR, bus.fullG, bus.fullB, s1, bus.GPIOEn, bus.done, bus.errFlag});
    end
    checks++;
    if (bus.GPIO !== 32'h0) begin
      errors++;
      $display("FAIL reset_gpio got=%h want=00000000", bus.GPIO);
    end
    rst = 1'b0;
    tick();
    $display("reset released");
  endtask

  task automatic test_frame();
    logic [31:0] exp_d [6];
    logic [2:0]  exp_s [6];
    exp_d = '{32'hA000_0000, 32'hB000_0000, 32'hC000_0000, 32'hA100_0001, 32'hB100_0001, 32'hC100_0001};
    exp_s = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001};
    wr(2'd0, exp_d[0]); wr(2'd0, exp_d[3]);
    wr(2'd1, exp_d[1]); wr(2'd1, exp_d[4]);
    wr(2'd2, exp_d[2]); wr(2'd2, exp_d[5]);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    checks++;
    if (s1 !== 3'b000 || bus.GPIOEn !== 1'b0) begin
      errors++;
      $display("FAIL frame_first_cycle got strobe=%b en=%b want strobe=000 en=0", s1, bus.GPIOEn);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (s1 !== exp_s[i] || bus.GPIO !== exp_d[i] || bus.GPIOEn !== 1'b1) begin
        errors++;
        $display("FAIL frame_beat%0d got strobe=%b data=%h en=%b want strobe=%b data=%h en=1",
                 i, s1, bus.GPIO, bus.GPIOEn, exp_s[i], exp_d[i]);
      end else begin
        $display("beat %0d strobe=%b data=%h", i, s1, bus.GPIO);
      end
    end
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.GPIOEn !== 1'b0 || s1 !== 3'b000) begin
      errors++;
      $display("FAIL frame_done got done=%b en=%b strobe=%b want done=1 en=0 strobe=000",
               bus.done, bus.GPIOEn, s1);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL frame_done_pulse got done=%b want 0", bus.done);
    end
  endtask

  task automatic test_r_empty();
    bit seen;
    wr(2'd1, 32'h2200_0001);
    wr(2'd2, 32'h3300_0001);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (s1 !== 3'b000 || bus.GPIOEn !== 1'b0) begin
        errors++;
        $display("FAIL r_empty_stall%0d got strobe=%b en=%b want strobe=000 en=0", i, s1, bus.GPIOEn);
      end
    end
    bus.wrEn   = 1'b1;
    bus.wrCh   = 2'd0;
    bus.wrData = 32'h1122_3344;
    tick();
    bus.wrEn = 1'b0;
    checks++;
    if (s1 !== 3'b000) begin
      errors++;
      $display("FAIL r_empty_no_bypass got strobe=%b want 000", s1);
    end
    tick();
    checks++;
    if (s1 !== 3'b100 || bus.GPIO !== 32'h1122_3344 || bus.GPIOEn !== 1'b1) begin
      errors++;
      $display("FAIL r_empty_r_beat got strobe=%b data=%h en=%b want strobe=100 data=11223344 en=1",
               s1, bus.GPIO, bus.GPIOEn);
    end
    tick();
    checks++;
    if (s1 !== 3'b010 || bus.GPIO !== 32'h2200_0001) begin
      errors++;
      $display("FAIL r_empty_g_beat got strobe=%b data=%h want strobe=010 data=22000001", s1, bus.GPIO);
    end
    tick();
    checks++;
    if (s1 !== 3'b001 || bus.GPIO !== 32'h3300_0001) begin
      errors++;
      $display("FAIL r_empty_b_beat got strobe=%b data=%h want strobe=001 data=33000001", s1, bus.GPIO);
    end
    wr(2'd0, 32'h1100_0002);
    wr(2'd1, 32'h2200_0002);
    wr(2'd2, 32'h3300_0002);
    wait_done(20, seen);
    checks++;
    if (seen !== 1'b1) begin
      errors++;
      $display("FAIL r_empty_done got done_seen=%b want 1", seen);
    end
    tick();
  endtask

  task automatic test_hold();
    logic [31:0] exp_d [5];
    logic [2:0]  exp_s [5];
    exp_d = '{32'hE000_0000, 32'hF100_0000, 32'hD000_0001, 32'hE000_0001, 32'hF100_0001};
    exp_s = '{3'b010, 3'b001, 3'b100, 3'b010, 3'b001};
    wr(2'd0, 32'hD000_0000); wr(2'd0, exp_d[2]);
    wr(2'd1, exp_d[0]);      wr(2'd1, exp_d[3]);
    wr(2'd2, exp_d[1]);      wr(2'd2, exp_d[4]);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    checks++;
    if (s1 !== 3'b100 || bus.GPIO !== 32'hD000_0000) begin
      errors++;
      $display("FAIL hold_first_r got strobe=%b data=%h want strobe=100 data=d0000000", s1, bus.GPIO);
    end
    bus.gpioHold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (s1 !== 3'b000 || bus.GPIO !== 32'hD000_0000 || bus.GPIOEn !== 1'b1) begin
        errors++;
        $display("FAIL hold_cycle%0d got strobe=%b data=%h en=%b want strobe=000 data=d0000000 en=1",
                 i, s1, bus.GPIO, bus.GPIOEn);
      end
    end
    bus.gpioHold = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (s1 !== exp_s[i] || bus.GPIO !== exp_d[i]) begin
        errors++;
        $display("FAIL hold_resume%0d got strobe=%b data=%h want strobe=%b data=%h",
                 i, s1, bus.GPIO, exp_s[i], exp_d[i]);
      end else begin
        $display("resume beat %0d strobe=%b data=%h", i, s1, bus.GPIO);
      end
    end
    tick();
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL hold_done got done=%b want 1", bus.done);
    end
    tick();
  endtask

  task automatic test_overflow();
    bit seen;
    for (int i = 0; i < 8; i++) wr(2'd0, 32'hF000_0000 + 32'(i));
    checks++;
    if (bus.fullR !== 1'b1 || bus.errFlag !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full got fullR=%b err=%b want fullR=1 err=0", bus.fullR, bus.errFlag);
    end
    wr(2'd0, 32'hDEAD_BEEF);
    checks++;
    if (bus.errFlag !== 1'b1 || bus.fullR !== 1'b1) begin
      errors++;
      $display("FAIL ovf_drop got err=%b fullR=%b want err=1 fullR=1", bus.errFlag, bus.fullR);
    end
    for (int i = 0; i < 8; i++) wr(2'd1, 32'h6000_0000 + 32'(i));
    for (int i = 0; i < 8; i++) wr(2'd2, 32'h7000_0000 + 32'(i));
    checks++;
    if (bus.fullG !== 1'b1 || bus.fullB !== 1'b1) begin
      errors++;
      $display("FAIL ovf_gb_full got fullG=%b fullB=%b want 1 1", bus.fullG, bus.fullB);
    end
    r_log.delete();
    bus.start = 1'b1;
    tick();
    bus.start  = 1'b0;
    bus.wrEn   = 1'b1;
    bus.wrCh   = 2'd0;
    bus.wrData = 32'hF000_0008;
    tick();
    bus.wrEn = 1'b0;
    checks++;
    if (s1 !== 3'b100 || bus.GPIO !== 32'hF000_0000 || bus.errFlag !== 1'b0 || bus.fullR !== 1'b1) begin
      errors++;
      $display("FAIL ovf_push_pop got strobe=%b data=%h err=%b fullR=%b want strobe=100 data=f0000000 err=0 fullR=1",
               s1, bus.GPIO, bus.errFlag, bus.fullR);
    end
    for (int f = 0; f < 4; f++) begin
      if (f > 0) begin
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
      end
      wait_done(40, seen);
      checks++;
      if (seen !== 1'b1) begin
        errors++;
        $display("FAIL ovf_frame%0d_done got done_seen=%b want 1", f, seen);
      end
    end
    checks++;
    if (r_log.size() != 8) begin
      errors++;
      $display("FAIL ovf_r_count got %0d want 8", r_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (r_log[i] !== 32'hF000_0000 + 32'(i)) begin
          errors++;
          $display("FAIL ovf_r_word%0d got %h want %h", i, r_log[i], 32'hF000_0000 + 32'(i));
        end
      end
    end
  endtask

  task automatic test_err_rst();
    // R still holds F0000008; bring every FIFO to 7 words
    for (int i = 0; i < 6; i++) wr(2'd0, 32'h8000_0000 + 32'(i));
    for (int i = 0; i < 7; i++) wr(2'd1, 32'h9000_0000 + 32'(i));
    for (int i = 0; i < 7; i++) wr(2'd2, 32'hA500_0000 + 32'(i));
    wr(2'd3, 32'h5555_AAAA);
    checks++;
    if (bus.errFlag !== 1'b1 || {bus.fullR, bus.fullG, bus.fullB} !== 3'b000) begin
      errors++;
      $display("FAIL invalid_ch got err=%b full=%b want err=1 full=000",
               bus.errFlag, {bus.fullR, bus.fullG, bus.fullB});
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    checks++;
    if (s1 !== 3'b100 || bus.GPIO !== 32'hF000_0008 || bus.GPIOEn !== 1'b1 || bus.errFlag !== 1'b0) begin
      errors++;
      $display("FAIL persist_r got strobe=%b data=%h en=%b err=%b want strobe=100 data=f0000008 en=1 err=0",
               s1, bus.GPIO, bus.GPIOEn, bus.errFlag);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({bus.fullR, bus.fullG, bus.fullB, s1, bus.GPIOEn, bus.done, bus.errFlag} !== 9'b0 || bus.GPIO !== 32'h0) begin
      errors++;
      $display("FAIL midframe_rst got flags=%b data=%h want flags=000000000 data=00000000",
               {bus.fullR, bus.fullG, bus.fullB, s1, bus.GPIOEn, bus.done, bus.errFlag}, bus.GPIO);
    end
    rst = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (s1 !== 3'b000) begin
        errors++;
        $display("FAIL flush_cycle%0d got strobe=%b want 000", i, s1);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    $display("error/reset scenario complete");
  endtask

  task automatic test_stream();
    int sidx [3];
    int rr;
    int bad [3];
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < SW; i++) sexp[c][i] = $urandom;
      sidx[c] = 0;
      bad[c]  = 0;
    end
    rr = 0;
    s_r.delete();
    s_g.delete();
    s_b.delete();
    s_done = 0;
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
    for (int cyc = 0; cyc < 8000; cyc++) begin
      if (s_done > 0) break;
      bus2.wrEn     = 1'b0;
      bus2.gpioHold = ($urandom_range(0, 7) == 0);
      if (sidx[rr] < SW && f2[rr] == 1'b0) begin
        bus2.wrEn   = 1'b1;
        bus2.wrCh   = 2'(rr);
        bus2.wrData = sexp[rr][sidx[rr]];
        sidx[rr]++;
      end
      rr = (rr == 2) ? 0 : rr + 1;
      tick();
    end
    bus2.wrEn     = 1'b0;
    bus2.gpioHold = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    $display("stream frame ended r=%0d g=%0d b=%0d done=%0d", s_r.size(), s_g.size(), s_b.size(), s_done);
    checks++;
    if (s_r.size() != SW || s_g.size() != SW || s_b.size() != SW) begin
      errors++;
      $display("FAIL stream_counts got r=%0d g=%0d b=%0d want %0d each", s_r.size(), s_g.size(), s_b.size(), SW);
    end else begin
      for (int i = 0; i < SW; i++) begin
        if (s_r[i] !== sexp[0][i]) bad[0]++;
        if (s_g[i] !== sexp[1][i]) bad[1]++;
        if (s_b[i] !== sexp[2][i]) bad[2]++;
      end
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (bad[c] != 0) begin
          errors++;
          $display("FAIL stream_order_ch%0d got %0d wrong words want 0", c, bad[c]);
        end
      end
    end
    checks++;
    if (s_done != 1) begin
      errors++;
      $display("FAIL stream_done got %0d pulses want 1", s_done);
    end
    checks++;
    if (bus2.errFlag !== 1'b0) begin
      errors++;
      $display("FAIL stream_err got %b want 0", bus2.errFlag);
    end
    checks++;
    if (onehot_err != 0) begin
      errors++;
      $display("FAIL strobe_onehot got %0d multi-strobe cycles want 0", onehot_err);
    end
  endtask

  initial begin
    errors        = 0;
    checks        = 0;
    s_done        = 0;
    onehot_err    = 0;
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.wrEn      = 1'b0;
    bus.wrCh      = 2'd0;
    bus.wrData    = 32'h0;
    bus.gpioHold  = 1'b0;
    bus2.start    = 1'b0;
    bus2.wrEn     = 1'b0;
    bus2.wrCh     = 2'd0;
    bus2.wrData   = 32'h0;
    bus2.gpioHold = 1'b0;
    test_reset();
    test_frame();
    test_r_empty();
    test_hold();
    test_overflow();
    test_err_rst();
    test_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
